// File: rtl/cpu_do_demux_pkg.sv
// Shared constants and FSM state type for the Z80 data-out demultiplexer.
package cpu_do_demux_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  localparam logic [7:0] LED_PORT_DEF      = 8'hFF;
  localparam logic [7:0] IOBYTE_PORT_DEF   = 8'hEF;
  localparam logic [7:0] PTR_DATA_PORT_DEF = 8'hC7;
  localparam logic [7:0] USB_DATA_PORT_DEF = 8'hAA;
  localparam logic [7:0] SD_DATA_PORT_DEF  = 8'h6C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } doState_t;

endpackage

// File: rtl/cpu_do_demux_if.sv
// Z80 write-side bus: control strobes, I/O port address and data-out byte.
interface cpu_do_demux_if;
  logic       z80_wr_n;
  logic       z80_iorq_n;
  logic [7:0] z80Addr;
  logic [7:0] cpuDataOut;

  modport master (output z80_wr_n, output z80_iorq_n, output z80Addr, output cpuDataOut);
  modport slave  (input  z80_wr_n, input  z80_iorq_n, input  z80Addr, input  cpuDataOut);
endinterface

// File: rtl/cpu_do_demux_sync2.sv
// Two-flop synchroniser for active-low async strobes; resets to 1 (inactive).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/cpu_do_demux.sv
// Z80 data-out demux: syncs WR#/IORQ#, settles, decodes port, loads latch or pulses strobe.
// Optional S100 forwarding of unmapped ports is enabled by defining CPU_DO_S100_FWD_EN.
module cpu_do_demux
  import cpu_do_demux_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [7:0]  LED_PORT      = LED_PORT_DEF,
  parameter logic [7:0]  IOBYTE_PORT   = IOBYTE_PORT_DEF,
  parameter logic [7:0]  PTR_DATA_PORT = PTR_DATA_PORT_DEF,
  parameter logic [7:0]  USB_DATA_PORT = USB_DATA_PORT_DEF,
  parameter logic [7:0]  SD_DATA_PORT  = SD_DATA_PORT_DEF
) (
  input  logic                 pll0_250MHz,
  input  logic                 reset,
  cpu_do_demux_if.slave        bus,
  output logic [7:0]           ledOut,
  output logic [7:0]           iobyteOut,
  output logic [7:0]           ptrData,
  output logic                 ptrStrobe,
  output logic [7:0]           usbTxD,
  output logic                 usbTxStrobe,
  output logic [7:0]           sdDataToDev,
  output logic                 sdWrStrobe,
  output logic [7:0]           s100DataOut,
  output logic                 s100WrStrobe,
  output logic                 busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic       w_wrSync;
  logic       w_iorqSync;
  logic       w_wr;
  logic       w_capture;
  logic [3:0] w_cntNext;
  doState_t   w_stateNext;

  doState_t   r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_led;
  logic [7:0] r_iobyte;
  logic [7:0] r_ptrData;
  logic       r_ptrStrobe;
  logic [7:0] r_usbTxD;
  logic       r_usbTxStrobe;
  logic [7:0] r_sdData;
  logic       r_sdWrStrobe;

  sync2 u_syncWr (
    .clk     (pll0_250MHz),
    .reset   (reset),
    .i_async (bus.z80_wr_n),
    .o_sync  (w_wrSync)
  );

  sync2 u_syncIorq (
    .clk     (pll0_250MHz),
    .reset   (reset),
    .i_async (bus.z80_iorq_n),
    .o_sync  (w_iorqSync)
  );

  assign w_wr = !w_wrSync && !w_iorqSync;

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Release of either strobe aborts SETTLE and ends HOLD.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_wr) begin
          w_cntNext   = SETTLE_LOAD;
          w_stateNext = SETTLE;
        end
      end
      SETTLE: begin
        if (!w_wr) begin
          w_stateNext = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_stateNext = COMMIT;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end
      COMMIT: w_stateNext = HOLD;
      HOLD: begin
        if (!w_wr) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      r_addr <= 8'h00;
      r_data <= 8'h00;
    end else if (w_capture) begin
      r_addr <= bus.z80Addr;
      r_data <= bus.cpuDataOut;
    end
  end

  // Decode priority follows parameter order so a colliding port resolves to the earlier target.
  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      r_led         <= 8'h00;
      r_iobyte      <= 8'h00;
      r_ptrData     <= 8'h00;
      r_ptrStrobe   <= 1'b0;
      r_usbTxD      <= 8'h00;
      r_usbTxStrobe <= 1'b0;
      r_sdData      <= 8'h00;
      r_sdWrStrobe  <= 1'b0;
    end else begin
      r_ptrStrobe   <= 1'b0;
      r_usbTxStrobe <= 1'b0;
      r_sdWrStrobe  <= 1'b0;
      if (r_state == COMMIT) begin
        if (r_addr == LED_PORT) begin
          r_led <= r_data;
        end else if (r_addr == IOBYTE_PORT) begin
          r_iobyte <= r_data;
        end else if (r_addr == PTR_DATA_PORT) begin
          r_ptrData   <= r_data;
          r_ptrStrobe <= 1'b1;
        end else if (r_addr == USB_DATA_PORT) begin
          r_usbTxD      <= r_data;
          r_usbTxStrobe <= 1'b1;
        end else if (r_addr == SD_DATA_PORT) begin
          r_sdData     <= r_data;
          r_sdWrStrobe <= 1'b1;
        end
      end
    end
  end

`ifdef CPU_DO_S100_FWD_EN
  logic       w_unmapped;
  logic [7:0] r_s100Data;
  logic       r_s100Strobe;

  assign w_unmapped = (r_addr != LED_PORT) && (r_addr != IOBYTE_PORT) &&
                      (r_addr != PTR_DATA_PORT) && (r_addr != USB_DATA_PORT) &&
                      (r_addr != SD_DATA_PORT);

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      r_s100Data   <= 8'h00;
      r_s100Strobe <= 1'b0;
    end else begin
      r_s100Strobe <= 1'b0;
      if ((r_state == COMMIT) && w_unmapped) begin
        r_s100Data   <= r_data;
        r_s100Strobe <= 1'b1;
      end
    end
  end

  assign s100DataOut  = r_s100Data;
  assign s100WrStrobe = r_s100Strobe;
`else
  assign s100DataOut  = 8'h00;
  assign s100WrStrobe = 1'b0;
`endif

  assign ledOut      = r_led;
  assign iobyteOut   = r_iobyte;
  assign ptrData     = r_ptrData;
  assign ptrStrobe   = r_ptrStrobe;
  assign usbTxD      = r_usbTxD;
  assign usbTxStrobe = r_usbTxStrobe;
  assign sdDataToDev = r_sdData;
  assign sdWrStrobe  = r_sdWrStrobe;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_cpu_do_demux.sv
// Directed self-checking bench for cpu_do_demux; honours CPU_DO_S100_FWD_EN for the S100 step.
module tb_cpu_do_demux;

  logic       clk;
  logic       reset;
  logic [7:0] ledOut, iobyteOut, ptrData, usbTxD, sdDataToDev, s100DataOut;
  logic       ptrStrobe, usbTxStrobe, sdWrStrobe, s100WrStrobe, busy;

  int checkCount = 0;
  int failCount  = 0;
  int ptrPulses  = 0;
  int usbPulses  = 0;
  int sdPulses   = 0;
  int s100Pulses = 0;
  int snapPtr, snapUsb, snapSd, snapS100;

  cpu_do_demux_if bus ();

  cpu_do_demux dut (
    .pll0_250MHz  (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .ledOut       (ledOut),
    .iobyteOut    (iobyteOut),
    .ptrData      (ptrData),
    .ptrStrobe    (ptrStrobe),
    .usbTxD       (usbTxD),
    .usbTxStrobe  (usbTxStrobe),
    .sdDataToDev  (sdDataToDev),
    .sdWrStrobe   (sdWrStrobe),
    .s100DataOut  (s100DataOut),
    .s100WrStrobe (s100WrStrobe),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ptrStrobe)    ptrPulses  <= ptrPulses + 1;
    if (usbTxStrobe)  usbPulses  <= usbPulses + 1;
    if (sdWrStrobe)   sdPulses   <= sdPulses + 1;
    if (s100WrStrobe) s100Pulses <= s100Pulses + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold WR#/IORQ# low for lowCycles edges, release, then wait until the FSM is back in IDLE.
  task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data, input int lowCycles);
    bus.z80Addr    = port;
    bus.cpuDataOut = data;
    bus.z80_iorq_n = 1'b0;
    bus.z80_wr_n   = 1'b0;
    tick(lowCycles);
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    tick(3);
  endtask

  initial begin
    reset          = 1'b1;
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    bus.z80Addr    = 8'h00;
    bus.cpuDataOut = 8'h00;
    tick(3);
    checkOutput("reset_led",   ledOut,    8'h00);
    checkOutput("reset_busy",  busy,      1'b0);
    checkOutput("reset_strb",  {ptrStrobe, usbTxStrobe, sdWrStrobe, s100WrStrobe}, 4'b0000);
    reset = 1'b0;
    tick(2);

    $display("[TB] LED write A5 -> FF");
    snapPtr = ptrPulses; snapUsb = usbPulses; snapSd = sdPulses;
    bus.z80Addr    = 8'hFF;
    bus.cpuDataOut = 8'hA5;
    bus.z80_iorq_n = 1'b0;
    bus.z80_wr_n   = 1'b0;
    tick(2);
    checkOutput("led_busy_c2", busy, 1'b0);
    tick(1);
    checkOutput("led_busy_c3", busy, 1'b1);
    tick(4);
    checkOutput("led_c7", ledOut, 8'h00);
    tick(1);
    checkOutput("led_c8", ledOut, 8'hA5);
    tick(12);
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    tick(2);
    checkOutput("led_busy_rel2", busy, 1'b1);
    tick(1);
    checkOutput("led_busy_rel3", busy, 1'b0);
    checkOutput("led_no_strobe", (ptrPulses - snapPtr) + (usbPulses - snapUsb) + (sdPulses - snapSd), 0);
    tick(2);

    $display("[TB] USB write 41 -> AA");
    snapUsb = usbPulses;
    bus.z80Addr    = 8'hAA;
    bus.cpuDataOut = 8'h41;
    bus.z80_iorq_n = 1'b0;
    bus.z80_wr_n   = 1'b0;
    tick(7);
    checkOutput("usb_strb_c7", usbTxStrobe, 1'b0);
    tick(1);
    checkOutput("usb_strb_c8", usbTxStrobe, 1'b1);
    checkOutput("usb_data_c8", usbTxD, 8'h41);
    tick(1);
    checkOutput("usb_strb_c9", usbTxStrobe, 1'b0);
    tick(11);
    checkOutput("usb_one_pulse", usbPulses - snapUsb, 1);
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    tick(4);
    checkOutput("usb_data_hold", usbTxD, 8'h41);

    $display("[TB] glitch on EF");
    bus.z80Addr    = 8'hEF;
    bus.cpuDataOut = 8'h5A;
    bus.z80_iorq_n = 1'b0;
    bus.z80_wr_n   = 1'b0;
    tick(4);
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    tick(6);
    checkOutput("glitch_iobyte", iobyteOut, 8'h00);
    checkOutput("glitch_idle", busy, 1'b0);

    $display("[TB] reset during SETTLE of SD write");
    snapSd = sdPulses;
    bus.z80Addr    = 8'h6C;
    bus.cpuDataOut = 8'h99;
    bus.z80_iorq_n = 1'b0;
    bus.z80_wr_n   = 1'b0;
    tick(4);
    checkOutput("sd_in_settle", busy, 1'b1);
    reset          = 1'b1;
    bus.z80_wr_n   = 1'b1;
    bus.z80_iorq_n = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_led",  ledOut, 8'h00);
    checkOutput("rst_usb",  usbTxD, 8'h00);
    checkOutput("rst_sd",   sdDataToDev, 8'h00);
    tick(10);
    checkOutput("rst_no_sd_strobe", sdPulses - snapSd, 0);
    applyStimulus(8'h6C, 8'h3C, 12);
    checkOutput("sd_one_pulse", sdPulses - snapSd, 1);
    checkOutput("sd_data", sdDataToDev, 8'h3C);

    $display("[TB] back-to-back printer writes");
    snapPtr = ptrPulses;
    applyStimulus(8'hC7, 8'h01, 12);
    checkOutput("ptr_first", ptrData, 8'h01);
    applyStimulus(8'hC7, 8'h02, 12);
    checkOutput("ptr_two_pulses", ptrPulses - snapPtr, 2);
    checkOutput("ptr_final", ptrData, 8'h02);

    $display("[TB] unmapped write 77 -> 30");
    snapPtr = ptrPulses; snapUsb = usbPulses; snapSd = sdPulses; snapS100 = s100Pulses;
    applyStimulus(8'h30, 8'h77, 12);
    checkOutput("unm_led",    ledOut,      8'h00);
    checkOutput("unm_iobyte", iobyteOut,   8'h00);
    checkOutput("unm_ptr",    ptrData,     8'h02);
    checkOutput("unm_sd",     sdDataToDev, 8'h3C);
    checkOutput("unm_usb",    usbTxD,      8'h00);
    checkOutput("unm_onboard_strobes", (ptrPulses - snapPtr) + (usbPulses - snapUsb) + (sdPulses - snapSd), 0);
`ifdef CPU_DO_S100_FWD_EN
    checkOutput("s100_data",   s100DataOut,           8'h77);
    checkOutput("s100_pulses", s100Pulses - snapS100, 1);
`else
    checkOutput("s100_data",   s100DataOut,           8'h00);
    checkOutput("s100_pulses", s100Pulses - snapS100, 0);
`endif

    $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_do_demux.md
# cpu_do_demux

Z80 data-out demultiplexer: the write-direction counterpart of the CPU data-in mux. It synchronises the asynchronous Z80 I/O write strobe into the `pll0_250MHz` domain and qualifies it with a settle window. It decodes the low I/O address, then either loads the selected on-board output latch or emits a one-cycle write strobe with the captured data byte. It sits between the Z80 core's data-out/control pins and the on-board peripherals: LED bar, IOBYTE, printer, USB UART TX, SD SPI, and the S100 bus.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles `wr` must stay asserted after sync before data is captured (1..15).
- `LED_PORT`, 8'hFF: LED latch port.
- `IOBYTE_PORT`, 8'hEF: IOBYTE latch port.
- `PTR_DATA_PORT`, 8'hC7: printer data port (latch + strobe).
- `USB_DATA_PORT`, 8'hAA: USB TX data port (strobe).
- `SD_DATA_PORT`, 8'h6C: SD SPI data port (strobe).

Ports:
- `pll0_250MHz`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `z80_wr_n`  in  1  Z80 WR#, asynchronous.
- `z80_iorq_n`  in  1  Z80 IORQ#, asynchronous.
- `z80Addr`  in  8  A7..A0 (I/O port number).
- `cpuDataOut`  in  8  Z80 data-out bus.
- `ledOut`  out  8  LED latch, reset 8'h00.
- `iobyteOut`  out  8  IOBYTE latch, reset 8'h00.
- `ptrData`  out  8  printer data latch, reset 8'h00.
- `ptrStrobe`  out  1  one-cycle printer strobe, reset 0.
- `usbTxD`  out  8  captured USB byte, reset 8'h00.
- `usbTxStrobe`  out  1  one-cycle, reset 0.
- `sdDataToDev`  out  8  captured SD byte, reset 8'h00.
- `sdWrStrobe`  out  1  one-cycle, reset 0.
- `s100DataOut`  out  8  captured byte for the S100 bus, reset 8'h00.
- `s100WrStrobe`  out  1  one-cycle; held 0 unless the macro is defined. Reset 0.
- `busy`  out  1  high in any state other than IDLE, reset 0.

## Operation
- `z80_wr_n` and `z80_iorq_n` each pass through a 2-flop synchroniser. The qualified write is `wr = !wr_s & !iorq_s`.
- FSM states:
  - IDLE: on `wr`, set cnt=SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: if `!wr`, go to IDLE with no effect (glitch abort). Else if cnt==0, capture `z80Addr`/`cpuDataOut` and go to COMMIT. Else decrement cnt.
  - COMMIT: 1 cycle. Load the decoded latch and pulse its strobe, then go to HOLD.
  - HOLD: wait for `!wr`, then go to IDLE. There is no re-trigger while `wr` stays asserted.
- Address and data are captured in a single register stage. Decode uses the captured address only.
- Strobe ports (`ptrStrobe`, `usbTxStrobe`, `sdWrStrobe`, `s100WrStrobe`) drive their data output from the same captured byte. The data is stable from COMMIT until the next COMMIT.
- An unmapped port with the macro absent produces no output change.
- A second write is accepted only after HOLD has seen `wr` released.
- Port-parameter collisions are illegal. If they occur, the first match in parameter list order wins.

## Timing
- Latches and strobes update on the clock edge that ends COMMIT, so they are visible on the next cycle.
- Latency from WR# low at the input to the strobe high is 2 (sync) + 1 (IDLE) + SETTLE_CYCLES + 1 (COMMIT) cycles. With defaults this is 8 cycles.
- Each strobe is high for exactly 1 cycle per accepted write.
- `reset` asserted in any state forces IDLE, all outputs to their reset values, and clears the synchroniser flops to 1 (inactive) on the next edge. A write in progress is dropped.
- IORQ# rising while WR# is still low is treated as release: abort in SETTLE, exit in HOLD.

## Configuration
- `CPU_DO_S100_FWD_EN` defined: any captured I/O port that matches none of the on-board parameters loads `s100DataOut` and pulses `s100WrStrobe` in COMMIT.
- Undefined: `s100DataOut` and `s100WrStrobe` are tied to 0, and unmapped writes are ignored.

## Structure
- The shared package holds the port-address constants and the FSM state enum (IDLE, SETTLE, COMMIT, HOLD).
- Sub-module `sync2`: a 2-flop synchroniser with reset value 1. It is instantiated once per async control input.
- The decode and latch logic stays in the top module.

## Test plan
- Write 8'hA5 to 8'hFF with WR# low for 20 cycles -> `ledOut`=8'hA5 from cycle 8. `busy` is high cycles 3..(release+3). No strobe pulses.
- Write 8'h41 to 8'hAA -> `usbTxStrobe` high for exactly 1 cycle with `usbTxD`=8'h41, and no second pulse while WR# is held.
- WR# low for 4 cycles (glitch shorter than the sync+settle window) with port 8'hEF -> `iobyteOut` unchanged at 8'h00, FSM back in IDLE.
- Reset asserted during SETTLE of a write to 8'h6C -> no `sdWrStrobe`, all outputs at reset values. The next full write of 8'h3C produces one strobe with 8'h3C.
- Back-to-back writes 8'h01 then 8'h02 to 8'hC7 with 3 idle cycles between them -> two `ptrStrobe` pulses, and `ptrData` ends at 8'h02.
- Write 8'h77 to 8'h30 -> with the macro, one `s100WrStrobe` with `s100DataOut`=8'h77. Without it, no output changes.
